fpu_arbiter: RTL



---
 rtl/fpu_arbiter_pkg.sv | 36 +++
 rtl/fpu_arbiter_if.sv | 55 +++++
 rtl/fpu_rsp_fifo.sv | 54 +++++
 rtl/fpu_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/fpu_arbiter_pkg.sv
// Shared definitions for the fpu arbiter slice: op and rounding encodings,
// flag bit positions and a width helper.
package fpu_arbiter_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3
   } fpu_op_e;

   typedef enum logic [1:0] {
      RM_NEAREST_EVEN = 2'd0,
      RM_ZERO         = 2'd1,
      RM_POS_INF      = 2'd2,
      RM_NEG_INF      = 2'd3
   } fpu_rmode_e;

   localparam int FPU_W    = 32;
   localparam int FLAGS_W  = 8;

   // Flag bit order: {snan, qnan, inf, ine, overflow, underflow, div_by_zero, zero}
   localparam int FLAG_SNAN        = 7;
   localparam int FLAG_QNAN        = 6;
   localparam int FLAG_INF         = 5;
   localparam int FLAG_INE         = 4;
   localparam int FLAG_OVERFLOW    = 3;
   localparam int FLAG_UNDERFLOW   = 2;
   localparam int FLAG_DIV_BY_ZERO = 1;
   localparam int FLAG_ZERO        = 0;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fpu_arbiter_if.sv
// Bundle of requester, core and response signals around the arbiter.
// Handshakes: a beat moves on a rising edge where valid and ready are both high; valid never waits on ready.
interface fpu_arbiter_if
   import fpu_arbiter_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int RFIFO_DEPTH = 8
);
   localparam int IDW = id_width(NREQ);
   localparam int CW  = $clog2(RFIFO_DEPTH + 1);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [3*NREQ-1:0]     req_op;
   logic [2*NREQ-1:0]     req_rmode;
   logic [32*NREQ-1:0]    req_opa;
   logic [32*NREQ-1:0]    req_opb;

   logic [2:0]            fpu_op;
   logic [1:0]            fpu_rmode;
   logic [FPU_W-1:0]      fpu_opa;
   logic [FPU_W-1:0]      fpu_opb;
   logic [FPU_W-1:0]      fpu_out;
   logic [FLAGS_W-1:0]    fpu_flags;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [FPU_W-1:0]      rsp_out;
   logic [FLAGS_W-1:0]    rsp_flags;

   logic [CW-1:0]         dbg_used;
   logic [CW-1:0]         dbg_count;

   modport slave (
      input  req_valid, req_op, req_rmode, req_opa, req_opb,
      output req_ready,
      output fpu_op, fpu_rmode, fpu_opa, fpu_opb,
      input  fpu_out, fpu_flags,
      output rsp_valid, rsp_id, rsp_out, rsp_flags,
      input  rsp_ready,
      output dbg_used, dbg_count
   );

   modport master (
      output req_valid, req_op, req_rmode, req_opa, req_opb,
      input  req_ready,
      input  fpu_op, fpu_rmode, fpu_opa, fpu_opb,
      output fpu_out, fpu_flags,
      input  rsp_valid, rsp_id, rsp_out, rsp_flags,
      output rsp_ready,
      input  dbg_used, dbg_count
   );

endinterface

// File: rtl/fpu_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO holding returned results.
// Head data reads as zero while empty so the response outputs stay clean.
module fpu_rsp_fifo #(
   parameter int WIDTH = 42,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_wr_valid,
   output logic                         o_wr_ready,
   input  logic [WIDTH-1:0]             i_wr_data,
   output logic                         o_rd_valid,
   input  logic                         i_rd_ready,
   output logic [WIDTH-1:0]             o_rd_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_wr_ready = (r_count != CW'(DEPTH));
   assign o_rd_valid = (r_count != '0);
   assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count    = r_count;
   assign w_wr       = i_wr_valid & o_wr_ready;
   assign w_rd       = o_rd_valid & i_rd_ready;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin front end for one shared fixed-latency fpu core, with a tag pipe
// tracking issued ops and a credit counter protecting the response FIFO.
module fpu_arbiter
   import fpu_arbiter_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int LATENCY     = 4,
   parameter int RFIFO_DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   fpu_arbiter_if.slave  bus
);
   localparam int IDW = id_width(NREQ);
   localparam int CW  = $clog2(RFIFO_DEPTH + 1);
   localparam int EW  = IDW + FPU_W + FLAGS_W;

   logic [IDW-1:0]              r_rr_ptr;
   logic [CW-1:0]               r_used;
   logic [LATENCY-1:0]          r_tag_v;
   logic [LATENCY-1:0][IDW-1:0] r_tag_id;
   logic [2:0]                  r_fpu_op;
   logic [1:0]                  r_fpu_rmode;
   logic [FPU_W-1:0]            r_fpu_opa;
   logic [FPU_W-1:0]            r_fpu_opb;

   logic                        w_found;
   logic [IDW-1:0]              w_gnt_id;
   logic                        w_issue;
   logic                        w_pop;
   logic                        w_fifo_wr_ready;
   logic                        w_fifo_rd_valid;
   logic [EW-1:0]               w_fifo_rd_data;
   logic [CW-1:0]               w_fifo_count;

   function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return IDW'(s);
   endfunction

   always_comb begin
      w_found  = 1'b0;
      w_gnt_id = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && bus.req_valid[wrap_idx(r_rr_ptr, k)]) begin
            w_found  = 1'b1;
            w_gnt_id = wrap_idx(r_rr_ptr, k);
         end
      end
   end

   // Counting in-flight ops as well as stored ones means a write can never find the FIFO full.
   assign w_issue       = w_found && (r_used < CW'(RFIFO_DEPTH));
   assign bus.req_ready = w_issue ? (NREQ'(1) << w_gnt_id) : '0;
   assign w_pop         = w_fifo_rd_valid & bus.rsp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr    <= '0;
         r_used      <= '0;
         r_tag_v     <= '0;
         r_tag_id    <= '0;
         r_fpu_op    <= '0;
         r_fpu_rmode <= '0;
         r_fpu_opa   <= '0;
         r_fpu_opb   <= '0;
      end else begin
         if (w_issue) begin
            r_fpu_op    <= bus.req_op[w_gnt_id*3 +: 3];
            r_fpu_rmode <= bus.req_rmode[w_gnt_id*2 +: 2];
            r_fpu_opa   <= bus.req_opa[w_gnt_id*32 +: 32];
            r_fpu_opb   <= bus.req_opb[w_gnt_id*32 +: 32];
            r_rr_ptr    <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
         end
         r_tag_v[0]  <= w_issue;
         r_tag_id[0] <= w_gnt_id;
         for (int s = 1; s < LATENCY; s++) begin
            r_tag_v[s]  <= r_tag_v[s-1];
            r_tag_id[s] <= r_tag_id[s-1];
         end
         case ({w_issue, w_pop})
            2'b10:   r_used <= r_used + 1'b1;
            2'b01:   r_used <= r_used - 1'b1;
            default: r_used <= r_used;
         endcase
      end
   end

   fpu_rsp_fifo #(
      .WIDTH (EW),
      .DEPTH (RFIFO_DEPTH)
   ) u_rsp_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_wr_valid (r_tag_v[LATENCY-1] & w_fifo_wr_ready),
      .o_wr_ready (w_fifo_wr_ready),
      .i_wr_data  ({r_tag_id[LATENCY-1], bus.fpu_out, bus.fpu_flags}),
      .o_rd_valid (w_fifo_rd_valid),
      .i_rd_ready (bus.rsp_ready),
      .o_rd_data  (w_fifo_rd_data),
      .o_count    (w_fifo_count)
   );

   assign bus.fpu_op    = r_fpu_op;
   assign bus.fpu_rmode = r_fpu_rmode;
   assign bus.fpu_opa   = r_fpu_opa;
   assign bus.fpu_opb   = r_fpu_opb;
   assign bus.rsp_valid = w_fifo_rd_valid;
   assign {bus.rsp_id, bus.rsp_out, bus.rsp_flags} = w_fifo_rd_data;
   assign bus.dbg_used  = r_used;
   assign bus.dbg_count = w_fifo_count;

endmodule
